cpu_mult_pipe: RTL and testbench

Parametrised, pipelined integer multiply unit for the Nios CPU datapath. It replaces the fixed three-partial-product 32-bit cell with a DATA_W-wide unit. The unit computes all four half-width partial products and sums them internally. It supports low-word and high-word results for signed, unsigned and mixed operands. It accepts operands in E stage, stalls under M_en, supports flush, and tags results with a valid bit, so the CPU no longer assembles partial products itself.

---
 rtl/cpu_mult_pkg.sv | 15 +
 rtl/cpu_mult_pp_cell.sv | 18 +
 rtl/cpu_mult_pipe.sv | 88 ++++++++
 tb/tb_cpu_mult_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mult_pkg.sv
// cpu_mult_pkg: op encodings, pipeline depth limits and operand-signedness helpers for the multiply unit.
package cpu_mult_pkg;
  localparam logic [1:0] MUL_OP_LO = 2'b00;
  localparam logic [1:0] MUL_OP_UU = 2'b01;
  localparam logic [1:0] MUL_OP_SU = 2'b10;
  localparam logic [1:0] MUL_OP_SS = 2'b11;
  localparam int PIPE_MIN = 2;
  localparam int PIPE_MAX = 3;
  function automatic logic op_signed_a(input logic [1:0] op);
    return (op == MUL_OP_SU) || (op == MUL_OP_SS);
  endfunction
  function automatic logic op_signed_b(input logic [1:0] op);
    return op == MUL_OP_SS;
  endfunction
endpackage

// File: rtl/cpu_mult_pp_cell.sv
// cpu_mult_pp_cell: registered unsigned half-width multiplier with load enable and async clear.
module cpu_mult_pp_cell #(
  parameter int HALF_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [HALF_W-1:0]     a,
  input  logic [HALF_W-1:0]     b,
  output logic [2*HALF_W-1:0]   p
);
  logic [2*HALF_W-1:0] p_d, p_q;
  always_comb p_d = en ? {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b} : p_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) p_q <= '0;
    else p_q <= p_d;
  assign p = p_q;
endmodule

// File: rtl/cpu_mult_pipe.sv
// cpu_mult_pipe: pipelined DATA_W multiplier; four unsigned partial products plus sign correction of the high word.
module cpu_mult_pipe
  import cpu_mult_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_valid,
  input  logic [1:0]        E_op,
  input  logic              M_en,
  input  logic              M_flush,
  output logic [DATA_W-1:0] M_result,
  output logic              M_valid
);
  localparam int HALF_W = DATA_W / 2;
  logic acc;
  logic [DATA_W-1:0] pp_ll, pp_lh, pp_hl, pp_hh;
  logic [1:0] op_d, op_q;
  logic [DATA_W-1:0] corr_a_d, corr_a_q, corr_b_d, corr_b_q;
  logic v1_d, v1_q, v2_d, v2_q;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0] hi, res, res2_d, res2_q;
  assign acc = E_valid & M_en;
  cpu_mult_pp_cell #(.HALF_W(HALF_W)) u_ll (.clk(clk), .reset_n(reset_n), .en(acc),
    .a(E_src1[HALF_W-1:0]), .b(E_src2[HALF_W-1:0]), .p(pp_ll));
  cpu_mult_pp_cell #(.HALF_W(HALF_W)) u_lh (.clk(clk), .reset_n(reset_n), .en(acc),
    .a(E_src1[HALF_W-1:0]), .b(E_src2[DATA_W-1:HALF_W]), .p(pp_lh));
  cpu_mult_pp_cell #(.HALF_W(HALF_W)) u_hl (.clk(clk), .reset_n(reset_n), .en(acc),
    .a(E_src1[DATA_W-1:HALF_W]), .b(E_src2[HALF_W-1:0]), .p(pp_hl));
  cpu_mult_pp_cell #(.HALF_W(HALF_W)) u_hh (.clk(clk), .reset_n(reset_n), .en(acc),
    .a(E_src1[DATA_W-1:HALF_W]), .b(E_src2[DATA_W-1:HALF_W]), .p(pp_hh));
  // Unsigned product corrected to signed by subtracting the other operand from the high word.
  always_comb begin
    op_d     = acc ? E_op : op_q;
    corr_a_d = acc ? ((op_signed_a(E_op) && E_src1[DATA_W-1]) ? E_src2 : '0) : corr_a_q;
    corr_b_d = acc ? ((op_signed_b(E_op) && E_src2[DATA_W-1]) ? E_src1 : '0) : corr_b_q;
    v1_d     = M_flush ? 1'b0 : (M_en ? E_valid : v1_q);
    prod     = {{DATA_W{1'b0}}, pp_ll}
             + {{HALF_W{1'b0}}, pp_lh, {HALF_W{1'b0}}}
             + {{HALF_W{1'b0}}, pp_hl, {HALF_W{1'b0}}}
             + {pp_hh, {DATA_W{1'b0}}};
    hi       = prod[2*DATA_W-1:DATA_W] - corr_a_q - corr_b_q;
    res      = (op_q == MUL_OP_LO) ? prod[DATA_W-1:0] : hi;
    res2_d   = M_en ? res : res2_q;
    v2_d     = M_flush ? 1'b0 : (M_en ? v1_q : v2_q);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      op_q     <= '0;
      corr_a_q <= '0;
      corr_b_q <= '0;
      v1_q     <= 1'b0;
      res2_q   <= '0;
      v2_q     <= 1'b0;
    end else begin
      op_q     <= op_d;
      corr_a_q <= corr_a_d;
      corr_b_q <= corr_b_d;
      v1_q     <= v1_d;
      res2_q   <= res2_d;
      v2_q     <= v2_d;
    end
  if (PIPE_STAGES > PIPE_MIN && PIPE_STAGES <= PIPE_MAX) begin : g_out_reg
    logic [DATA_W-1:0] res3_d, res3_q;
    logic v3_d, v3_q;
    always_comb begin
      res3_d = M_en ? res2_q : res3_q;
      v3_d   = M_flush ? 1'b0 : (M_en ? v2_q : v3_q);
    end
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        res3_q <= '0;
        v3_q   <= 1'b0;
      end else begin
        res3_q <= res3_d;
        v3_q   <= v3_d;
      end
    assign M_result = res3_q;
    assign M_valid  = v3_q;
  end else begin : g_no_out_reg
    assign M_result = res2_q;
    assign M_valid  = v2_q;
  end
endmodule

// File: tb/tb_cpu_mult_pipe.sv
// tb_cpu_mult_pipe: scoreboard bench for the pipelined multiplier (DATA_W=32, PIPE_STAGES=2).
module tb_cpu_mult_pipe;
  localparam int W  = 32;
  localparam int PS = 2;
  logic clk = 1'b0;
  logic reset_n;
  logic [W-1:0] E_src1, E_src2;
  logic E_valid;
  logic [1:0] E_op;
  logic M_en, M_flush;
  logic [W-1:0] M_result;
  logic M_valid;
  int vectors = 0;
  int errors  = 0;
  logic [W-1:0] exp_q[$];
  logic en_s;
  logic [W-1:0] exp_v;

  always #5 clk = ~clk;

  cpu_mult_pipe #(.DATA_W(W), .PIPE_STAGES(PS)) dut (
    .clk(clk), .reset_n(reset_n), .E_src1(E_src1), .E_src2(E_src2), .E_valid(E_valid),
    .E_op(E_op), .M_en(M_en), .M_flush(M_flush), .M_result(M_result), .M_valid(M_valid));

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic [63:0] ea, eb, p;
    ea = op[1] ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == 2'b11) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // A new result is present after every enabled edge that leaves M_valid high.
  always @(posedge clk) begin
    en_s = M_en;
    #1;
    if (reset_n && M_valid && en_s) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got M_valid=1 M_result=%h, expected no output", M_result);
      end else begin
        exp_v = exp_q.pop_front();
        if (M_result !== exp_v) begin
          errors++;
          $display("FAIL result: got %h, expected %h", M_result, exp_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic en, input logic fl, input logic track);
    E_valid = v; E_src1 = a; E_src2 = b; E_op = op; M_en = en; M_flush = fl;
    if (track && v && en && !fl) exp_q.push_back(model(a, b, op));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic drain(input string name);
    idle(1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d results outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_quiet(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (M_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_quiet: got M_valid=%b, expected 0", name, M_valid);
      end
    end
  endtask

  task automatic issue_timed(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input string name);
    int cnt;
    E_valid = 1'b1; E_src1 = a; E_src2 = b; E_op = op; M_en = 1'b1; M_flush = 1'b0;
    exp_q.push_back(model(a, b, op));
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
      E_valid = 1'b0;
    end while (!M_valid && cnt < 10);
    vectors++;
    if (cnt !== PS) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, expected %0d", name, cnt, PS);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; E_valid = 1'b0; E_src1 = '0; E_src2 = '0; E_op = 2'b00; M_en = 1'b1; M_flush = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 2;
    if (M_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", M_valid); end
    if (M_result !== '0) begin errors++; $display("FAIL reset_result: got %h, expected 0", M_result); end
    reset_n = 1'b1;
    check_quiet("post_reset", 3);
  endtask

  task automatic test_basic;
    issue_timed(32'h0001_0000, 32'h0001_0000, 2'b00, "mul_lo");
    issue_timed(32'h0001_0000, 32'h0001_0000, 2'b01, "mulxuu");
    drain("basic");
  endtask

  task automatic test_corners;
    for (int op = 0; op < 4; op++) drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'(op), 1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 2'b11, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 2'b11, 1'b1, 1'b0, 1'b1);
    drain("corners");
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 32'h8000_0000, 32'h0000_0002, 2'b11, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'h8000_0000, 32'h0000_0002, 2'b01, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (M_valid !== 1'b1) begin errors++; $display("FAIL b2b_first: got M_valid=%b, expected 1", M_valid); end
    drive(1'b0, '0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (M_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: got M_valid=%b, expected 1", M_valid); end
    drain("b2b");
  endtask

  task automatic test_stall;
    drive(1'b1, 32'h0000_1234, 32'h0000_0010, 2'b00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (M_valid !== 1'b0) begin errors++; $display("FAIL stall_early: got M_valid=%b, expected 0", M_valid); end
    end
    drive(1'b0, '0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (M_valid !== 1'b1) begin errors++; $display("FAIL stall_release: got M_valid=%b, expected 1", M_valid); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h5555_5555, 32'h3, 2'b01, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (M_valid !== 1'b1 || M_result !== 32'h0001_2340) begin
        errors++;
        $display("FAIL stall_hold: got M_valid=%b M_result=%h, expected 1 00012340", M_valid, M_result);
      end
    end
    drive(1'b0, '0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (M_valid !== 1'b0) begin errors++; $display("FAIL stall_pulse: got M_valid=%b, expected 0", M_valid); end
    drain("stall");
  endtask

  task automatic test_flush;
    drive(1'b1, 32'h1111_1111, 32'h2222_2222, 2'b11, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h3333_3333, 32'h4444_4444, 2'b01, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (M_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got M_valid=%b, expected 0", M_valid); end
    check_quiet("flush", 3);
    issue_timed(32'h0000_0007, 32'hFFFF_FFFD, 2'b10, "post_flush");
    drive(1'b1, 32'h9999_9999, 32'h7777_7777, 2'b11, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    check_quiet("flush_stalled", 3);
    drain("flush");
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 32'hABCD_0123, 32'h0000_0100, 2'b00, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'hFFFF_0000, 32'h1234_5678, 2'b11, 1'b1, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    vectors += 2;
    if (M_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b, expected 0", M_valid); end
    if (M_result !== '0) begin errors++; $display("FAIL async_reset_result: got %h, expected 0", M_result); end
    @(negedge clk);
    reset_n = 1'b1;
    check_quiet("reset_mid", 4);
    issue_timed(32'h0000_0003, 32'h0000_0005, 2'b00, "post_reset_mid");
    drain("reset_mid");
  endtask

  task automatic test_random;
    for (int i = 0; i < 80; i++)
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, 1'b0, 1'b1);
    drain("random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
